// File: rtl/rf_wr_sched_if.sv
// rtl/rf_wr_sched_if.sv - issue, writeback request and register file write bundle
interface rf_wr_sched_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
);
   localparam int NREG = 1 << ADDR_W;

   logic              rsv_en;
   logic [ADDR_W-1:0] rsv_addr;
   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic [DATA_W-1:0] data0;
   logic              gnt0;
   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic [DATA_W-1:0] data1;
   logic              gnt1;
   logic              wr;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [NREG-1:0]   busy;
   logic [1:0]        err;

   modport master (
      output rsv_en, rsv_addr,
      output req0, addr0, data0,
      output req1, addr1, data1,
      input  gnt0, gnt1,
      input  wr, waddr, wdata, busy, err
   );

   modport slave (
      input  rsv_en, rsv_addr,
      input  req0, addr0, data0,
      input  req1, addr1, data1,
      output gnt0, gnt1,
      output wr, waddr, wdata, busy, err
   );
endinterface

// File: rtl/rf_wr_sched.sv
// rtl/rf_wr_sched.sv - round-robin register file write port scheduler with busy scoreboard
module rf_wr_sched #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 3
) (
   input  logic          clk,
   input  logic          rstn,
   rf_wr_sched_if.slave  bus
);
   localparam int NREG = 1 << ADDR_W;

   logic              wr_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              last_q;
   logic [NREG-1:0]   busy_q;
   logic [1:0]        err_q;

   logic              g0;
   logic              g1;
   logic [NREG-1:0]   set_vec;
   logic [NREG-1:0]   clr_vec;
   logic              err0_hit;
   logic              err1_hit;

   // Round-robin arbitration: on a conflict the port not granted last wins
   always_comb begin
      g0 = 1'b0;
      g1 = 1'b0;
      if (bus.req0 && bus.req1) begin
         g0 = last_q;
         g1 = ~last_q;
      end else begin
         g0 = bus.req0;
         g1 = bus.req1;
      end
   end

   // Scoreboard set/clear vectors and error detection for this edge
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (bus.rsv_en) set_vec[bus.rsv_addr] = 1'b1;
      if (wr_q)       clr_vec[waddr_q]      = 1'b1;
      err0_hit = bus.rsv_en & busy_q[bus.rsv_addr] & ~clr_vec[bus.rsv_addr];
      err1_hit = wr_q & ~busy_q[waddr_q];
   end

   // Write stage register, arbitration history, scoreboard and sticky errors
   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         last_q  <= 1'b1;
         busy_q  <= '0;
         err_q   <= 2'b00;
      end else begin
         wr_q <= g0 | g1;
         if (g1) begin
            waddr_q <= bus.addr1;
            wdata_q <= bus.data1;
            last_q  <= 1'b1;
         end else if (g0) begin
            waddr_q <= bus.addr0;
            wdata_q <= bus.data0;
            last_q  <= 1'b0;
         end
         // Reserve wins over a same-edge clear of the same register
         busy_q <= (busy_q & ~clr_vec) | set_vec;
         err_q  <= err_q | {err1_hit, err0_hit};
      end
   end

   assign bus.gnt0  = g0;
   assign bus.gnt1  = g1;
   assign bus.wr    = wr_q;
   assign bus.waddr = waddr_q;
   assign bus.wdata = wdata_q;
   assign bus.busy  = busy_q;
   assign bus.err   = err_q;
endmodule

// File: tb/tb_rf_wr_sched.sv
// tb/tb_rf_wr_sched.sv - self-checking bench for rf_wr_sched
module tb_rf_wr_sched;
   logic clk = 1'b0;
   logic rstn;
   int   n_checks = 0;
   int   n_errors = 0;

   rf_wr_sched_if #(.DATA_W(16), .ADDR_W(3)) bus ();

   rf_wr_sched #(.DATA_W(16), .ADDR_W(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rstn;
      logic        rsv_en;
      logic [2:0]  rsv_addr;
      logic        req0;
      logic [2:0]  addr0;
      logic [15:0] data0;
      logic        req1;
      logic [2:0]  addr1;
      logic [15:0] data1;
      logic        g0;
      logic        g1;
      logic        wr;
      logic [2:0]  waddr;
      logic [15:0] wdata;
      logic [7:0]  busy;
      logic [1:0]  err;
   } vec_t;

   vec_t vt[$];

   // reference model state
   bit          m_wr;
   int          m_waddr;
   int          m_wdata;
   bit          m_busy[8];
   bit          m_err[2];
   int          m_last;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic set_in(input logic rn, input logic re, input logic [2:0] ra,
                         input logic q0, input logic [2:0] a0, input logic [15:0] d0,
                         input logic q1, input logic [2:0] a1, input logic [15:0] d1);
      rstn         = rn;
      bus.rsv_en   = re;
      bus.rsv_addr = ra;
      bus.req0     = q0;
      bus.addr0    = a0;
      bus.data0    = d0;
      bus.req1     = q1;
      bus.addr1    = a1;
      bus.data1    = d1;
   endtask

   function automatic vec_t mk(input logic rn, input logic re, input logic [2:0] ra,
                               input logic q0, input logic [2:0] a0, input logic [15:0] d0,
                               input logic q1, input logic [2:0] a1, input logic [15:0] d1,
                               input logic g0, input logic g1, input logic w,
                               input logic [2:0] wa, input logic [15:0] wd,
                               input logic [7:0] b, input logic [1:0] e);
      vec_t v;
      v.rstn = rn; v.rsv_en = re; v.rsv_addr = ra;
      v.req0 = q0; v.addr0 = a0; v.data0 = d0;
      v.req1 = q1; v.addr1 = a1; v.data1 = d1;
      v.g0 = g0; v.g1 = g1; v.wr = w; v.waddr = wa; v.wdata = wd; v.busy = b; v.err = e;
      return v;
   endfunction

   // One clock edge of the architectural behaviour, given which port won this cycle
   task automatic model_edge(input int winner, input logic [2:0] a0, input logic [15:0] d0,
                             input logic [2:0] a1, input logic [15:0] d1);
      bit nb[8];
      if (!rstn) begin
         m_wr = 0; m_waddr = 0; m_wdata = 0; m_last = 1;
         foreach (m_busy[r]) m_busy[r] = 0;
         m_err[0] = 0; m_err[1] = 0;
         return;
      end
      if (m_wr && !m_busy[m_waddr]) m_err[1] = 1;
      for (int r = 0; r < 8; r++) begin
         bit cleared  = m_wr && (m_waddr == r);
         bit reserved = bus.rsv_en && (int'(bus.rsv_addr) == r);
         if (reserved && m_busy[r] && !cleared) m_err[0] = 1;
         nb[r] = reserved || (m_busy[r] && !cleared);
      end
      m_busy = nb;
      if (winner == 0) begin
         m_wr = 1; m_waddr = a0; m_wdata = d0; m_last = 0;
      end else if (winner == 1) begin
         m_wr = 1; m_waddr = a1; m_wdata = d1; m_last = 1;
      end else begin
         m_wr = 0;
      end
   endtask

   function automatic logic [7:0] model_busy();
      logic [7:0] b;
      for (int r = 0; r < 8; r++) b[r] = m_busy[r];
      return b;
   endfunction

   initial begin
      bit          p0, p1;
      logic [2:0]  ra0, ra1;
      logic [15:0] rd0, rd1;
      bit          eg0, eg1;
      int          win;

      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;

      vt.push_back(mk(0,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,2'b00));
      vt.push_back(mk(0,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,2'b00));
      vt.push_back(mk(1,1,5, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h20,2'b00));
      vt.push_back(mk(1,0,0, 1,5,16'hBEEF, 0,0,16'h0,    1,0, 1,5,16'hBEEF, 8'h20,2'b00));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,5,16'hBEEF, 8'h00,2'b00));
      vt.push_back(mk(0,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,2'b00));
      vt.push_back(mk(1,0,0, 1,1,16'h1111, 1,2,16'h2222, 1,0, 1,1,16'h1111, 8'h00,2'b00));
      vt.push_back(mk(1,0,0, 1,1,16'h1111, 1,2,16'h2222, 0,1, 1,2,16'h2222, 8'h00,2'b10));
      vt.push_back(mk(1,0,0, 1,1,16'h1111, 1,2,16'h2222, 1,0, 1,1,16'h1111, 8'h00,2'b10));
      vt.push_back(mk(1,0,0, 1,1,16'h1111, 1,2,16'h2222, 0,1, 1,2,16'h2222, 8'h00,2'b10));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,2,16'h2222, 8'h00,2'b10));
      vt.push_back(mk(0,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,2'b00));
      vt.push_back(mk(1,1,3, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h08,2'b00));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    1,3,16'h0033, 0,1, 1,3,16'h0033, 8'h08,2'b00));
      vt.push_back(mk(1,1,3, 0,0,16'h0,    0,0,16'h0,    0,0, 0,3,16'h0033, 8'h08,2'b00));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,3,16'h0033, 8'h08,2'b00));
      vt.push_back(mk(0,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,2'b00));
      vt.push_back(mk(1,1,4, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h10,2'b00));
      vt.push_back(mk(1,1,4, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h10,2'b01));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    1,6,16'h0066, 0,1, 1,6,16'h0066, 8'h10,2'b01));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,6,16'h0066, 8'h10,2'b11));
      vt.push_back(mk(1,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,6,16'h0066, 8'h10,2'b11));
      vt.push_back(mk(0,0,0, 0,0,16'h0,    0,0,16'h0,    0,0, 0,0,16'h0,    8'h00,2'b00));

      foreach (vt[i]) begin
         set_in(vt[i].rstn, vt[i].rsv_en, vt[i].rsv_addr, vt[i].req0, vt[i].addr0, vt[i].data0,
                vt[i].req1, vt[i].addr1, vt[i].data1);
         #3;
         check($sformatf("vec%0d gnt0", i), 32'(bus.gnt0), 32'(vt[i].g0));
         check($sformatf("vec%0d gnt1", i), 32'(bus.gnt1), 32'(vt[i].g1));
         @(posedge clk); #1;
         check($sformatf("vec%0d wr", i),    32'(bus.wr),    32'(vt[i].wr));
         check($sformatf("vec%0d waddr", i), 32'(bus.waddr), 32'(vt[i].waddr));
         check($sformatf("vec%0d wdata", i), 32'(bus.wdata), 32'(vt[i].wdata));
         check($sformatf("vec%0d busy", i),  32'(bus.busy),  32'(vt[i].busy));
         check($sformatf("vec%0d err", i),   32'(bus.err),   32'(vt[i].err));
      end

      // Reset arriving while a load write sits in the write stage
      set_in(1, 0, 0, 0, 0, 0, 1, 7, 16'h0077);
      #3 check("midrst gnt1", 32'(bus.gnt1), 32'd1);
      @(posedge clk); #1;
      check("midrst wr before reset", 32'(bus.wr), 32'd1);
      set_in(0, 0, 0, 1, 1, 16'h0101, 1, 2, 16'h0202);
      @(posedge clk); #1;
      check("midrst wr dropped", 32'(bus.wr), 32'd0);
      check("midrst busy", 32'(bus.busy), 32'd0);
      check("midrst err", 32'(bus.err), 32'd0);
      set_in(1, 0, 0, 1, 1, 16'h0101, 1, 2, 16'h0202);
      #3;
      check("midrst conflict gnt0", 32'(bus.gnt0), 32'd1);
      check("midrst conflict gnt1", 32'(bus.gnt1), 32'd0);
      @(posedge clk); #1;
      check("midrst waddr", 32'(bus.waddr), 32'd1);
      check("midrst wdata", 32'(bus.wdata), 32'h0101);
      check("midrst err after", 32'(bus.err), 32'd0);

      // Randomized traffic against the reference model
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      model_edge(-1, 0, 0, 0, 0);
      #1;
      p0 = 0; p1 = 0; ra0 = 0; ra1 = 0; rd0 = 0; rd1 = 0;
      for (int c = 0; c < 600; c++) begin
         if (!p0 && ($urandom_range(0, 1) == 1)) begin
            p0 = 1; ra0 = 3'($urandom_range(0, 7)); rd0 = 16'($urandom);
         end
         if (!p1 && ($urandom_range(0, 1) == 1)) begin
            p1 = 1; ra1 = 3'($urandom_range(0, 7)); rd1 = 16'($urandom);
         end
         set_in(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
                3'($urandom_range(0, 7)), p0, ra0, rd0, p1, ra1, rd1);
         eg0 = p0 && (!p1 || m_last == 1);
         eg1 = p1 && (!p0 || m_last == 0);
         #3;
         check("rnd gnt0", 32'(bus.gnt0), 32'(eg0));
         check("rnd gnt1", 32'(bus.gnt1), 32'(eg1));
         win = eg0 ? 0 : (eg1 ? 1 : -1);
         @(posedge clk);
         model_edge(win, ra0, rd0, ra1, rd1);
         if (rstn && eg0) p0 = 0;
         if (rstn && eg1) p1 = 0;
         #1;
         check("rnd wr",    32'(bus.wr),    32'(m_wr));
         check("rnd waddr", 32'(bus.waddr), 32'(m_waddr));
         check("rnd wdata", 32'(bus.wdata), 32'(m_wdata));
         check("rnd busy",  32'(bus.busy),  32'(model_busy()));
         check("rnd err",   32'(bus.err),   32'({m_err[1], m_err[0]}));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
